// File: rtl/fp_result_unpacker.sv
// Decodes binary32 results into sign/exponent/mantissa/class records and queues them in a DEPTH-entry FIFO.
// Latency: push at edge N is visible at the outputs after edge N; in_ready = !full, independent of out_ready.
// Optional statistics counters are built only when FP_UNPACK_STATS_EN is defined.
module fp_result_unpacker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [8:0]       out_exp,
    output logic [23:0]      out_mant,
    output logic [2:0]       out_class,
    output logic             out_ovf,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] nan_cnt,
    output logic [CNT_W-1:0] inf_cnt,
    output logic [CNT_W-1:0] ovf_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_DENORM = 3'd1,
        CLS_NORMAL = 3'd2,
        CLS_INF    = 3'd3,
        CLS_NAN    = 3'd4
    } cls_e;

    typedef struct packed {
        logic        sign;
        logic [8:0]  exp;
        logic [23:0] mant;
        logic [2:0]  cls;
        logic        ovf;
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          dec;
    rec_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        dec      = '0;
        dec.sign = in_data[31];
        dec.ovf  = in_ovf;
        if (in_data[30:23] == 8'd0) begin
            if (in_data[22:0] == 23'd0) begin
                dec.cls = CLS_ZERO;
            end else begin
                dec.cls  = CLS_DENORM;
                dec.exp  = 9'h182;
                dec.mant = {1'b0, in_data[22:0]};
            end
        end else if (in_data[30:23] == 8'hff) begin
            dec.exp  = 9'h080;
            dec.mant = {1'b0, in_data[22:0]};
            dec.cls  = (in_data[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
        end else begin
            dec.cls  = CLS_NORMAL;
            dec.exp  = {1'b0, in_data[30:23]} - 9'd127;
            dec.mant = {1'b1, in_data[22:0]};
        end
    end

    // Storage is not reset; stale entries are masked by out_valid below.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head      = out_valid ? mem[rd_ptr] : '0;
    assign out_sign  = head.sign;
    assign out_exp   = head.exp;
    assign out_mant  = head.mant;
    assign out_class = head.cls;
    assign out_ovf   = head.ovf;

`ifdef FP_UNPACK_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nan_cnt <= '0;
            inf_cnt <= '0;
            ovf_cnt <= '0;
        end else if (stat_clr) begin
            nan_cnt <= '0;
            inf_cnt <= '0;
            ovf_cnt <= '0;
        end else if (push) begin
            if (dec.cls == CLS_NAN && nan_cnt != '1) begin
                nan_cnt <= nan_cnt + CNT_W'(1);
            end
            if (dec.cls == CLS_INF && inf_cnt != '1) begin
                inf_cnt <= inf_cnt + CNT_W'(1);
            end
            if (in_ovf && ovf_cnt != '1) begin
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign nan_cnt = '0;
    assign inf_cnt = '0;
    assign ovf_cnt = '0;
`endif
endmodule

// File: doc/fp_result_unpacker.md
Name: fp_result_unpacker

Overview:
- Decoder-side counterpart to the fpalu single-precision add/sub unit.
- Accepts packed IEEE-754 binary32 results plus the overflow flag, one per valid/ready transfer.
- Splits each result into sign, unbiased exponent and mantissa with the hidden bit, and classifies it.
- Buffers decoded records in a small FIFO for downstream consumers such as the result logger or checker.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CNT_W, 16: width of the saturating statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has a result.
- in_ready  output  1  block can accept; equals !full.
- in_data  input  32  packed binary32 result.
- in_ovf  input  1  overflow flag accompanying in_data.
- out_valid  output  1  decoded record available (FIFO not empty).
- out_ready  input  1  downstream accepts the record.
- out_sign  output  1  sign bit.
- out_exp  output  9  unbiased exponent, two's complement.
- out_mant  output  24  mantissa including hidden bit.
- out_class  output  3  0=ZERO, 1=DENORM, 2=NORMAL, 3=INF, 4=NAN.
- out_ovf  output  1  stored overflow flag.
- stat_clr  input  1  synchronous clear of the statistics counters.
- nan_cnt  output  CNT_W  count of NaN records accepted.
- inf_cnt  output  CNT_W  count of INF records accepted.
- ovf_cnt  output  CNT_W  count of records accepted with in_ovf=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty; rd/wr pointers and occupancy count = 0.
  - in_ready=1, out_valid=0.
  - All record outputs = 0.
  - All counters = 0.
- Accept: push occurs when in_valid & in_ready at a rising edge. Decode is combinational on in_data; the decoded record is written into the FIFO.
- Latency: a record pushed at edge N into an empty FIFO gives out_valid=1 after edge N.
- Pop: occurs when out_valid & out_ready at a rising edge.
- Output ordering: out_* always reflect the head entry, in strict FIFO order. Outputs hold stable while out_valid=1 and out_ready=0.
- Decode (e = in_data[30:23], f = in_data[22:0]):
  - e=0, f=0 -> ZERO; exp=0, mant=0.
  - e=0, f!=0 -> DENORM; exp=-126 (9'h182), mant={1'b0,f}.
  - 1<=e<=254 -> NORMAL; exp=e-127, mant={1'b1,f}.
  - e=255, f=0 -> INF; exp=+128 (9'h080), mant=0.
  - e=255, f!=0 -> NAN; exp=+128, mant={1'b0,f}.
  - out_sign = in_data[31] in every class.
- Full: in_ready=0 when count==DEPTH. in_ready does not depend on out_ready, so there is no push while full even if a pop occurs in the same cycle.
- Empty: out_valid=0; out_ready is ignored.
- Simultaneous push and pop (neither full nor empty): count unchanged, both pointers advance.
- Pointers: wrap modulo DEPTH.
- Count: width clog2(DEPTH)+1.
- Counters: increment on push only, and saturate at all-ones.
- stat_clr: takes priority over an increment in the same cycle.
- Reset mid-operation: all buffered records are discarded immediately; no partial transfer completes.

Optional Feature:
- Macro: FP_UNPACK_STATS_EN.
- Defined: nan_cnt, inf_cnt and ovf_cnt are implemented as described.
- Undefined: the counter registers are not built; nan_cnt, inf_cnt and ovf_cnt are tied to 0, stat_clr is ignored, and the port list is unchanged.

Test Plan:
- Push 32'h0deeee00 (ovf=0), out_ready=1 -> next cycle out_valid=1, sign=0, exp=9'h19C (-100), mant=24'hEEEE00, class=NORMAL.
- Push 32'hf5550005 (ovf=1) -> sign=1, exp=9'h06B (107), mant=24'hD50005, class=NORMAL, out_ovf=1; ovf_cnt=1 with stats enabled.
- Push 32'h7f800000, 32'h7fc00000, 32'h80000000, 32'h00000001 -> classes INF, NAN, ZERO (sign=1), DENORM (exp=9'h182, mant=24'h000001); inf_cnt=1, nan_cnt=1.
- DEPTH=4, out_ready=0, in_valid held high for 6 cycles with distinct data -> in_ready drops after the 4th push. Then raise out_ready -> 4 records appear in order, one per cycle, and in_ready reasserts the cycle after the first pop.
- FIFO holding 2 records, push and pop in the same cycle -> count stays 2, ordering preserved.
- Assert rst=0 asynchronously between clock edges with 3 records buffered -> out_valid=0 and in_ready=1 immediately, counters=0. After release, the first new push is output next.
